ula_arbiter: RTL

- Shares one ULA datapath (A/reg_sel/instru/valid_ula in, data_out/valid_out back) among NUM_REQ requesters.
- Round-robin arbitration, one operation in flight, response routed back to the winning requester.
- Watchdog timeout so a missing valid_out cannot hang the arbiter.
- Sits between the requester masters and the ULA slave; drives the ULA mst side.

---
 rtl/ula_arb_pkg.sv | 19 +
 rtl/ula_rr_pick.sv | 30 +++
 rtl/ula_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ula_arb_pkg.sv
// Shared types for the ULA arbiter: FSM state encoding, latched operation, default timeout.
package ula_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [15:0] a;
        logic [1:0]  reg_sel;
        logic [1:0]  instru;
    } op_t;

    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/ula_rr_pick.sv
// Round-robin picker: first set bit of req searching upward from rr_ptr+1 with wrap.
module ula_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        logic [IDX_W-1:0] j;
        j     = '0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // k = NUM_REQ lands back on rr_ptr itself, so the last owner is considered last
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one ULA among NUM_REQ requesters, with a WAIT watchdog.
// Optional ULA_ARB_PRIO0_EN: requester 0 gets fixed absolute priority over the round robin.
module ula_arbiter
    import ula_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic                  clk_ula,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*16-1:0] req_A,
    input  logic [NUM_REQ*2-1:0]  req_reg_sel,
    input  logic [NUM_REQ*2-1:0]  req_instru,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic [15:0]           A,
    output logic [1:0]            reg_sel,
    output logic [1:0]            instru,
    output logic                  valid_ula,
    input  logic [31:0]           data_out,
    input  logic                  valid_out
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_q, rr_d, grant_q, grant_d;
    op_t                  op_q, op_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 valid_ula_q, valid_ula_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;

    op_t                  req_op [NUM_REQ];
    logic [NUM_REQ-1:0]   pick_req, pick_oh, win_oh;
    logic [IDX_W-1:0]     pick_idx, win_idx;
    logic                 pick_any, win_any, upd_rr;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_op
        assign req_op[g] = {req_A[16*g+15:16*g], req_reg_sel[2*g+1:2*g], req_instru[2*g+1:2*g]};
    end

    ula_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req    (pick_req),
        .rr_ptr (rr_q),
        .grant  (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
`ifdef ULA_ARB_PRIO0_EN
        // requester 0 bypasses the rotation and leaves rr_ptr untouched
        pick_req = req_valid & ~NUM_REQ'(1);
        if (req_valid[0]) begin
            win_oh  = NUM_REQ'(1);
            win_idx = '0;
            win_any = 1'b1;
            upd_rr  = 1'b0;
        end else begin
            win_oh  = pick_oh;
            win_idx = pick_idx;
            win_any = pick_any;
            upd_rr  = 1'b1;
        end
`else
        pick_req = req_valid;
        win_oh   = pick_oh;
        win_idx  = pick_idx;
        win_any  = pick_any;
        upd_rr   = 1'b1;
`endif
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        valid_ula_d = 1'b0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = '0;
        case (state_q)
            IDLE: begin
                // ready is masked while reset is held so every output reads 0
                if (win_any && rst) begin
                    req_ready   = win_oh;
                    op_d        = req_op[win_idx];
                    grant_d     = win_idx;
                    if (upd_rr) rr_d = win_idx;
                    valid_ula_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (valid_out) begin
                    rsp_data_d  = data_out;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = NUM_REQ'(1) << grant_q;
                    state_d     = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = NUM_REQ'(1) << grant_q;
                    state_d     = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_ula or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_q        <= IDX_W'(NUM_REQ - 1);
            grant_q     <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            valid_ula_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            valid_ula_q <= valid_ula_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign A         = op_q.a;
    assign reg_sel   = op_q.reg_sel;
    assign instru    = op_q.instru;
    assign valid_ula = valid_ula_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule
